// File: rtl/led_pkg.sv
// Shared LED frame constants and the frame_assembler state encoding.
package led_pkg;

    localparam int unsigned NUM_LEDS     = 6;
    localparam int unsigned BITS_PER_LED = 24;
    localparam int unsigned FRAME_BITS   = NUM_LEDS * BITS_PER_LED;
    localparam int unsigned FRAME_BYTES  = FRAME_BITS / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } fa_state_e;

endpackage

// File: rtl/byte_scaler.sv
// Combinational brightness scaling of one colour byte: (data * (brightness + 1)) >> 8.
module byte_scaler (
    input  logic [7:0] data_i,
    input  logic [7:0] brightness_i,
    output logic [7:0] result_o
);

    // Product peaks at 255 * 256, so 16 bits hold it without overflow.
    assign result_o = 8'((16'(data_i) * (16'(brightness_i) + 16'd1)) >> 8);

endmodule

// File: rtl/frame_assembler.sv
// Collects a sync-delimited byte stream into a shadow frame and commits it to rgb with a go pulse.
// Optional brightness scaling of each accepted byte is enabled by defining FRAME_BRIGHTNESS_EN.
module frame_assembler #(
    parameter int unsigned NUM_LEDS    = led_pkg::NUM_LEDS,
    parameter int unsigned FRAME_BYTES = 3 * NUM_LEDS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      frame_sync,
    input  logic                                      byte_valid,
    input  logic [7:0]                                byte_data,
`ifdef FRAME_BRIGHTNESS_EN
    input  logic [7:0]                                brightness,
`endif
    output logic [led_pkg::BITS_PER_LED*NUM_LEDS-1:0] rgb,
    output logic                                      go,
    output logic                                      frame_err
);

    import led_pkg::fa_state_e;
    import led_pkg::IDLE;
    import led_pkg::COLLECT;
    import led_pkg::COMMIT;
    import led_pkg::BITS_PER_LED;

    localparam int unsigned FRAME_W = BITS_PER_LED * NUM_LEDS;
    localparam int unsigned CNT_W   = $clog2(FRAME_BYTES + 1);
    localparam int unsigned LAST    = FRAME_BYTES - 1;
    localparam logic [FRAME_W-1:0] LANE_MASK = FRAME_W'(8'hFF);

    fa_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [FRAME_W-1:0] rgb_q, rgb_d;
    logic               go_q, go_d;
    logic               err_q, err_d;
    logic               ovr_q, ovr_d;

    logic               wr_en_c;
    logic [CNT_W-1:0]   wr_idx_c;
    logic [FRAME_W-1:0] base_c;
    logic [31:0]        shamt_c;
    logic [7:0]         store_byte_c;

`ifdef FRAME_BRIGHTNESS_EN
    byte_scaler u_byte_scaler (
        .data_i       (byte_data),
        .brightness_i (brightness),
        .result_o     (store_byte_c)
    );
`else
    assign store_byte_c = byte_data;
`endif

    // ovr_q marks "a frame has completed since the last sync": stray bytes are then overruns.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        rgb_d    = rgb_q;
        ovr_d    = ovr_q;
        go_d     = 1'b0;
        err_d    = 1'b0;
        wr_en_c  = 1'b0;
        wr_idx_c = cnt_q;
        base_c   = shadow_q;
        shamt_c  = 32'd0;

        unique case (state_q)
            COLLECT: begin
                err_d   = frame_sync && (cnt_q != '0);
                wr_en_c = byte_valid;
            end
            COMMIT: begin
                rgb_d   = shadow_q;
                go_d    = 1'b1;
                ovr_d   = 1'b1;
                state_d = IDLE;
            end
            default: ;
        endcase

        // Sync restarts collection from any state; a coincident byte becomes byte 0.
        if (frame_sync) begin
            state_d  = COLLECT;
            cnt_d    = '0;
            shadow_d = '0;
            base_c   = '0;
            ovr_d    = 1'b0;
            wr_en_c  = byte_valid;
            wr_idx_c = '0;
        end else if (byte_valid && (state_q != COLLECT) && ovr_d) begin
            err_d = 1'b1;
        end

        if (wr_en_c) begin
            shamt_c  = 32'd8 * (32'(LAST) - 32'(wr_idx_c));
            shadow_d = (base_c & ~(LANE_MASK << shamt_c)) | (FRAME_W'(store_byte_c) << shamt_c);
            if (wr_idx_c == CNT_W'(LAST)) begin
                state_d = COMMIT;
                cnt_d   = '0;
            end else begin
                state_d = COLLECT;
                cnt_d   = wr_idx_c + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            rgb_q    <= '0;
            go_q     <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            rgb_q    <= rgb_d;
            go_q     <= go_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rgb       = rgb_q;
    assign go        = go_q;
    assign frame_err = err_q;

endmodule
